adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched_pkg.sv | 22 ++
 rtl/adder_sched_ripple.sv | 23 ++
 rtl/adder_sched.sv | 131 +++++++++++++
 tb/tb_adder_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the word-serial two-requester adder.
package adder_sched_pkg;

  localparam int unsigned WORD_W        = 16;
  localparam int unsigned WORDS_MAX_DEF = 4;
  localparam int unsigned LEN_W         = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Limit a requested word count (minus one) to what the instance can hold.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned      words_max);
    logic [LEN_W-1:0] lim;
    lim = LEN_W'(words_max - 1);
    return (len > lim) ? lim : len;
  endfunction

endpackage

// File: rtl/adder_sched_ripple.sv
// Single 16-bit ripple-carry adder, the only arithmetic unit of the scheduler.
module sixteenbit_ripple
  import adder_sched_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum_c,
  output logic              cout_c
);

  logic [WORD_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    assign sum_c[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout_c = carry[WORD_W];

endmodule

// File: rtl/adder_sched.sv
// Two-requester multi-word adder: round-robin grant, then one 16-bit word per
// cycle through a shared ripple adder, result held until the consumer takes it.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int unsigned WORDS_MAX = WORDS_MAX_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid0,
  input  logic                          req_valid1,
  output logic                          req_ready0,
  output logic                          req_ready1,
  input  logic [WORD_W*WORDS_MAX-1:0]   req_x0,
  input  logic [WORD_W*WORDS_MAX-1:0]   req_x1,
  input  logic [WORD_W*WORDS_MAX-1:0]   req_y0,
  input  logic [WORD_W*WORDS_MAX-1:0]   req_y1,
  input  logic [LEN_W-1:0]              req_len0,
  input  logic [LEN_W-1:0]              req_len1,
  input  logic                          req_cin0,
  input  logic                          req_cin1,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [WORD_W*WORDS_MAX-1:0]   rsp_sum,
  output logic                          rsp_cout
);

  localparam int unsigned IDX_W = (WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1;

  state_t state_q, state_d;

  logic                             last_q;
  logic                             grant0_c, grant1_c, accept_c, sel_c;
  logic [WORDS_MAX-1:0][WORD_W-1:0] x_q, y_q, sum_q;
  logic [IDX_W-1:0]                 k_q, len_q;
  logic                             cin_q, carry_q, cout_q, id_q, valid_q;
  logic [WORD_W-1:0]                add_sum_c;
  logic                             add_cin_c, add_cout_c;
  logic                             last_word_c;

  // Round-robin arbitration; a tie goes to the requester not granted last.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if ((state_q == IDLE) && !reset) begin
      if (req_valid0 && req_valid1) begin
        grant0_c = last_q;
        grant1_c = !last_q;
      end else begin
        grant0_c = req_valid0;
        grant1_c = req_valid1;
      end
    end
  end

  assign accept_c    = grant0_c | grant1_c;
  assign sel_c       = grant1_c;
  assign req_ready0  = grant0_c;
  assign req_ready1  = grant1_c;
  assign last_word_c = (k_q == len_q);

  // Word 0 takes the requester's carry-in; later words chain the stored carry.
  assign add_cin_c = (k_q == '0) ? cin_q : carry_q;

  sixteenbit_ripple u_add (
    .a      (x_q[k_q]),
    .b      (y_q[k_q]),
    .cin    (add_cin_c),
    .sum_c  (add_sum_c),
    .cout_c (add_cout_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c)    state_d = RUN;
      RUN:     if (last_word_c) state_d = DONE;
      DONE:    if (rsp_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Operand capture, per-word accumulation and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      cin_q   <= 1'b0;
      len_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_d == DONE);
      if (accept_c) begin
        last_q  <= sel_c;
        id_q    <= sel_c;
        x_q     <= sel_c ? req_x1 : req_x0;
        y_q     <= sel_c ? req_y1 : req_y0;
        cin_q   <= sel_c ? req_cin1 : req_cin0;
        len_q   <= IDX_W'(clamp_len(sel_c ? req_len1 : req_len0, WORDS_MAX));
        k_q     <= '0;
        carry_q <= 1'b0;
        sum_q   <= '0;
        cout_q  <= 1'b0;
      end
      if (state_q == RUN) begin
        sum_q[k_q] <= add_sum_c;
        carry_q    <= add_cout_c;
        if (last_word_c) cout_q <= add_cout_c;
        else             k_q    <= k_q + IDX_W'(1);
      end
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched: a cycle model of grant/latency/result rules
// checked every cycle, plus literal expectations for the key scenarios.
module tb_adder_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned NB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        v0, v1, r0, r1, c0, c1, rv, rr, rid, rcout;
  logic [63:0] x0, x1, y0, y1, rsum;
  logic [1:0]  l0, l1;

  logic        bv0, br0, br1, bc, brv, brr, bid, bcout;
  logic [31:0] bx, by, bsum;
  logic [1:0]  bl;

  int errors = 0;
  int checks = 0;

  adder_sched #(.WORDS_MAX(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(v0), .req_valid1(v1), .req_ready0(r0), .req_ready1(r1),
    .req_x0(x0), .req_x1(x1), .req_y0(y0), .req_y1(y1),
    .req_len0(l0), .req_len1(l1), .req_cin0(c0), .req_cin1(c1),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_sum(rsum), .rsp_cout(rcout)
  );

  adder_sched #(.WORDS_MAX(NB)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid0(bv0), .req_valid1(1'b0), .req_ready0(br0), .req_ready1(br1),
    .req_x0(bx), .req_x1(32'h0), .req_y0(by), .req_y1(32'h0),
    .req_len0(bl), .req_len1(2'd0), .req_cin0(bc), .req_cin1(1'b0),
    .rsp_valid(brv), .rsp_ready(brr), .rsp_id(bid), .rsp_sum(bsum), .rsp_cout(bcout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 computing, 2 holding a result.
  bit          mon_en = 1'b0;
  int          m_phase = 0;
  int          m_left = 0;
  bit          m_last = 1'b1;
  bit          m_id, m_cout, e0, e1;
  logic [63:0] m_sum;
  logic [64:0] full;
  int          nbits, mlen;

  always @(negedge clk) begin
    if (mon_en) begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (m_phase == 0 && !reset) begin
        if (v0 && v1) begin
          e0 = m_last;
          e1 = !m_last;
        end else begin
          e0 = v0;
          e1 = v1;
        end
      end
      chk("ready0", 64'(r0), 64'(e0));
      chk("ready1", 64'(r1), 64'(e1));
      chk("rsp_valid", 64'(rv), 64'(m_phase == 2));
      if (m_phase == 2) begin
        chk("rsp_sum", rsum, m_sum);
        chk("rsp_cout", 64'(rcout), 64'(m_cout));
        chk("rsp_id", 64'(rid), 64'(m_id));
      end
      if (reset) begin
        m_phase = 0;
        m_last  = 1'b1;
      end else begin
        case (m_phase)
          0: if (e0 || e1) begin
            m_id   = e1;
            m_last = e1;
            mlen   = int'(e1 ? l1 : l0);
            full   = {1'b0, (e1 ? x1 : x0)} + {1'b0, (e1 ? y1 : y0)} + 65'(e1 ? c1 : c0);
            nbits  = (mlen + 1) * 16;
            m_sum  = 64'(full & ((65'd1 << nbits) - 65'd1));
            m_cout = full[nbits];
            m_left = mlen + 1;
            m_phase = 1;
          end
          1: begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
          default: if (rr) m_phase = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int max_cyc, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (rv) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", max_cyc);
    end
  endtask

  task automatic release_rsp();
    rr = 1'b1;
    tick();
    rr = 1'b0;
  endtask

  int lat;

  initial begin
    reset = 1'b1;
    {v0, v1, c0, c1, rr} = '0;
    {x0, x1, y0, y1} = '0;
    {l0, l1} = '0;
    {bv0, bc, brr} = '0;
    {bx, by} = '0;
    bl = '0;
    repeat (3) tick();
    v0 = 1'b1;
    #1;
    chk("reset_ready0", 64'(r0), 64'd0);
    chk("reset_valid", 64'(rv), 64'd0);
    chk("reset_sum", rsum, 64'd0);
    chk("reset_cout", 64'(rcout), 64'd0);
    chk("reset_id", 64'(rid), 64'd0);
    v0 = 1'b0;
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Single word wrap with carry out.
    v0 = 1'b1; x0 = 64'hFFFF; y0 = 64'h0001; c0 = 1'b0; l0 = 2'd0;
    tick();
    v0 = 1'b0;
    wait_rsp(20, lat);
    chk("single_lat", 64'(lat), 64'd1);
    chk("single_sum", rsum, 64'h0);
    chk("single_cout", 64'(rcout), 64'd1);
    chk("single_id", 64'(rid), 64'd0);
    release_rsp();

    // Four-word carry chain.
    v0 = 1'b1; x0 = 64'h0000_FFFF_FFFF_FFFF; y0 = 64'h1; c0 = 1'b0; l0 = 2'd3;
    tick();
    v0 = 1'b0;
    wait_rsp(20, lat);
    chk("chain_lat", 64'(lat), 64'd4);
    chk("chain_sum", rsum, 64'h0001_0000_0000_0000);
    chk("chain_cout", 64'(rcout), 64'd0);
    release_rsp();

    // Carry-in on word 0, upper operand words ignored.
    v0 = 1'b1; x0 = 64'hAAAA_BBBB_CCCC_1234; y0 = 64'h0; c0 = 1'b1; l0 = 2'd0;
    tick();
    v0 = 1'b0;
    wait_rsp(20, lat);
    chk("cin_sum", rsum, 64'h1235);
    chk("cin_cout", 64'(rcout), 64'd0);
    release_rsp();
    c0 = 1'b0;

    // Contention from reset: grants alternate 0,1,0,1.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    x0 = 64'h5; y0 = 64'h6; l0 = 2'd0;
    x1 = 64'h0001_FFFF; y1 = 64'h1; l1 = 2'd1; c1 = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(20, lat);
      chk("rr_id", 64'(rid), 64'(i % 2));
      chk("rr_sum", rsum, (i % 2 == 0) ? 64'hB : 64'h2_0000);
      release_rsp();
    end
    v0 = 1'b0; v1 = 1'b0;
    tick();

    // Backpressure: result held with a competing request waiting.
    v1 = 1'b1; x1 = 64'h0000_1111_FFFF_8000; y1 = 64'h0000_2222_0001_8000; l1 = 2'd2;
    tick();
    v1 = 1'b0;
    wait_rsp(20, lat);
    chk("bp_lat", 64'(lat), 64'd3);
    v0 = 1'b1; x0 = 64'h10; y0 = 64'h20; l0 = 2'd0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rv), 64'd1);
      chk("bp_sum", rsum, 64'h0000_3334_0001_0000);
      chk("bp_id", 64'(rid), 64'd1);
      chk("bp_ready0", 64'(r0), 64'd0);
      tick();
    end
    release_rsp();
    chk("bp_after_valid", 64'(rv), 64'd0);
    chk("bp_after_ready0", 64'(r0), 64'd1);
    tick();
    v0 = 1'b0;
    wait_rsp(20, lat);
    chk("bp_next_sum", rsum, 64'h30);
    release_rsp();

    // Reset in the middle of a four-word add.
    v0 = 1'b1; x0 = 64'h0001_0002_0003_0004; y0 = 64'h0005_0006_0007_0008; l0 = 2'd3;
    tick();
    v0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v0 = 1'b1; x0 = 64'h7; y0 = 64'h8; l0 = 2'd0;
    #1;
    chk("mid_reset_valid", 64'(rv), 64'd0);
    chk("mid_reset_ready0", 64'(r0), 64'd1);
    tick();
    v0 = 1'b0;
    wait_rsp(20, lat);
    chk("mid_reset_lat", 64'(lat), 64'd1);
    chk("mid_reset_sum", rsum, 64'hF);
    release_rsp();

    // Two-word instance: length 3 clamps to two words.
    bv0 = 1'b1; bx = 32'h0001_FFFF; by = 32'h0000_0001; bc = 1'b0; bl = 2'd3;
    #1;
    chk("clamp_ready", 64'(br0), 64'd1);
    tick();
    bv0 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (brv) begin
        lat = i;
        break;
      end
    end
    chk("clamp_lat", 64'(lat), 64'd2);
    chk("clamp_sum", 64'(bsum), 64'h0002_0000);
    chk("clamp_cout", 64'(bcout), 64'd0);
    chk("clamp_id", 64'(bid), 64'd0);
    brr = 1'b1;
    tick();
    brr = 1'b0;
    chk("clamp_release", 64'(brv), 64'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
